// File: rtl/muldiv_share_arbiter.sv
// Shares one HI/LO multiply/divide unit between two 2a requesters.
// Holds an ownership lock on HI/LO from the first producer op until the owner reads LO or the lock times out.
module muldiv_share_arbiter #(
  parameter int unsigned LOCK_TIMEOUT = 64,
  parameter int unsigned CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [2:0]  req0_opcode_2a,
  input  logic        req0_active_2a,
  input  logic [31:0] req0_rs_data_2a,
  input  logic [31:0] req0_rt_data_2a,
  output logic        req0_stall_2a,
  output logic [31:0] req0_rd_data_3a,
  input  logic [2:0]  req1_opcode_2a,
  input  logic        req1_active_2a,
  input  logic [31:0] req1_rs_data_2a,
  input  logic [31:0] req1_rt_data_2a,
  output logic        req1_stall_2a,
  output logic [31:0] req1_rd_data_3a,
  output logic [2:0]  mul_opcode_2a,
  output logic        mul_active_2a,
  output logic [31:0] mul_rs_data_2a,
  output logic [31:0] mul_rt_data_2a,
  input  logic        mul_stall_2a,
  input  logic [31:0] mul_rd_data_3a,
  output logic [1:0]  owner
);

  localparam logic [2:0] MUL_MULT  = 3'd0;
  localparam logic [2:0] MUL_MULTU = 3'd1;
  localparam logic [2:0] MUL_DIV   = 3'd2;
  localparam logic [2:0] MUL_DIVU  = 3'd3;
  localparam logic [2:0] MUL_MTHI  = 3'd4;
  localparam logic [2:0] MUL_MTLO  = 3'd5;
  localparam logic [2:0] MUL_MFHI  = 3'd6;
  localparam logic [2:0] MUL_MFLO  = 3'd7;

  // State encoding doubles as the owner field.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rr_last_q;
  logic [1:0]       rd_sel_q;

  logic       gnt0_c;
  logic       gnt1_c;
  logic       acc0_c;
  logic       acc1_c;
  logic [2:0] acc_op_c;
  logic       expired_c;

  function automatic logic is_producer(input logic [2:0] op);
    return (op == MUL_MULT) || (op == MUL_MULTU) || (op == MUL_DIV) ||
           (op == MUL_DIVU) || (op == MUL_MTHI)  || (op == MUL_MTLO);
  endfunction

  function automatic logic is_reader(input logic [2:0] op);
    return (op == MUL_MFHI) || (op == MUL_MFLO);
  endfunction

  // Grant: round-robin when unlocked, owner only when locked (even if the owner is idle).
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gnt0_c = req0_active_2a & (~req1_active_2a | rr_last_q);
        gnt1_c = req1_active_2a & (~req0_active_2a | ~rr_last_q);
      end
      ST_OWN0: gnt0_c = 1'b1;
      ST_OWN1: gnt1_c = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    mul_opcode_2a  = 3'd0;
    mul_rs_data_2a = 32'h0;
    mul_rt_data_2a = 32'h0;
    if (gnt1_c) begin
      mul_opcode_2a  = req1_opcode_2a;
      mul_rs_data_2a = req1_rs_data_2a;
      mul_rt_data_2a = req1_rt_data_2a;
    end else if (gnt0_c) begin
      mul_opcode_2a  = req0_opcode_2a;
      mul_rs_data_2a = req0_rs_data_2a;
      mul_rt_data_2a = req0_rt_data_2a;
    end
  end

  assign mul_active_2a = (gnt0_c & req0_active_2a) | (gnt1_c & req1_active_2a);
  assign req0_stall_2a = req0_active_2a & (~gnt0_c | mul_stall_2a);
  assign req1_stall_2a = req1_active_2a & (~gnt1_c | mul_stall_2a);

  assign acc0_c    = gnt0_c & req0_active_2a & ~mul_stall_2a;
  assign acc1_c    = gnt1_c & req1_active_2a & ~mul_stall_2a;
  assign acc_op_c  = acc1_c ? req1_opcode_2a : req0_opcode_2a;
  // Expiry on the cycle the count would reach LOCK_TIMEOUT.
  assign expired_c = (cnt_q >= CNT_W'(LOCK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rr_last_q <= 1'b1;
      rd_sel_q  <= 2'b00;
    end else begin
      rd_sel_q <= {acc1_c & is_reader(req1_opcode_2a), acc0_c & is_reader(req0_opcode_2a)};
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (acc0_c | acc1_c) begin
            rr_last_q <= acc1_c;
            if (is_producer(acc_op_c)) state_q <= acc1_c ? ST_OWN1 : ST_OWN0;
          end
        end
        ST_OWN0, ST_OWN1: begin
          // An accepted owner op beats expiry in the same cycle.
          if (acc0_c | acc1_c) begin
            cnt_q <= '0;
            if (acc_op_c == MUL_MFLO) state_q <= ST_IDLE;
          end else if (expired_c) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign owner           = state_q;
  assign req0_rd_data_3a = rd_sel_q[0] ? mul_rd_data_3a : 32'h0;
  assign req1_rd_data_3a = rd_sel_q[1] ? mul_rd_data_3a : 32'h0;

endmodule

// File: tb/tb_muldiv_share_arbiter.sv
// Bench for muldiv_share_arbiter: per-cycle vectors checked mid-cycle, read data via a scoreboard queue,
// with a small HI/LO unit stub responding to the arbiter's 2a outputs.
module tb_muldiv_share_arbiter;

  localparam int unsigned LT = 12;

  localparam logic [2:0] MULT = 3'd0;
  localparam logic [2:0] DIV  = 3'd2;
  localparam logic [2:0] MTHI = 3'd4;
  localparam logic [2:0] MFHI = 3'd6;
  localparam logic [2:0] MFLO = 3'd7;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [2:0]  req0_opcode_2a, req1_opcode_2a;
  logic        req0_active_2a, req1_active_2a;
  logic [31:0] req0_rs_data_2a, req0_rt_data_2a, req1_rs_data_2a, req1_rt_data_2a;
  logic        req0_stall_2a, req1_stall_2a;
  logic [31:0] req0_rd_data_3a, req1_rd_data_3a;
  logic [2:0]  mul_opcode_2a;
  logic        mul_active_2a;
  logic [31:0] mul_rs_data_2a, mul_rt_data_2a;
  logic        mul_stall_2a;
  logic [31:0] mul_rd_data_3a;
  logic [1:0]  owner;

  muldiv_share_arbiter #(.LOCK_TIMEOUT(LT), .CNT_W(16)) dut (
    .clk(clk), .rst_b(rst_b),
    .req0_opcode_2a(req0_opcode_2a), .req0_active_2a(req0_active_2a),
    .req0_rs_data_2a(req0_rs_data_2a), .req0_rt_data_2a(req0_rt_data_2a),
    .req0_stall_2a(req0_stall_2a), .req0_rd_data_3a(req0_rd_data_3a),
    .req1_opcode_2a(req1_opcode_2a), .req1_active_2a(req1_active_2a),
    .req1_rs_data_2a(req1_rs_data_2a), .req1_rt_data_2a(req1_rt_data_2a),
    .req1_stall_2a(req1_stall_2a), .req1_rd_data_3a(req1_rd_data_3a),
    .mul_opcode_2a(mul_opcode_2a), .mul_active_2a(mul_active_2a),
    .mul_rs_data_2a(mul_rs_data_2a), .mul_rt_data_2a(mul_rt_data_2a),
    .mul_stall_2a(mul_stall_2a), .mul_rd_data_3a(mul_rd_data_3a),
    .owner(owner)
  );

  always #5 clk = ~clk;

  // Unit stub: HI/LO state updated by ops the arbiter issues, read data one cycle later.
  logic [31:0] hi = 32'hA5A5_0001;
  logic [31:0] lo = 32'h5A5A_0002;
  logic [31:0] rd_q = 32'h0;
  assign mul_rd_data_3a = rd_q;

  always @(posedge clk) begin
    rd_q <= 32'h0;
    if (mul_active_2a && !mul_stall_2a) begin
      case (mul_opcode_2a)
        MULT: {hi, lo} <= 64'(mul_rs_data_2a) * 64'(mul_rt_data_2a);
        DIV: if (mul_rt_data_2a != 32'h0) begin
          lo <= mul_rs_data_2a / mul_rt_data_2a;
          hi <= mul_rs_data_2a % mul_rt_data_2a;
        end
        MTHI: hi <= mul_rs_data_2a;
        MFHI: rd_q <= hi;
        MFLO: rd_q <= lo;
        default: ;
      endcase
    end
  end

  typedef struct {
    logic        a0;
    logic [2:0]  op0;
    logic [31:0] rs0, rt0;
    logic        a1;
    logic [2:0]  op1;
    logic [31:0] rs1, rt1;
    logic        ms;
    logic        e_st0, e_st1, e_mact;
    logic [2:0]  e_mop;
    logic [31:0] e_mrs, e_mrt;
    logic [1:0]  e_own;
    logic [1:0]  e_rdsel;
    logic [31:0] e_rdval;
  } vec_t;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] val;
  } rd_exp_t;

  int total = 0;
  int bad = 0;
  rd_exp_t sb[$];
  vec_t tbl[$];

  function automatic vec_t v(
    input logic a0, input logic [2:0] op0, input logic [31:0] rs0, input logic [31:0] rt0,
    input logic a1, input logic [2:0] op1, input logic [31:0] rs1, input logic [31:0] rt1,
    input logic ms, input logic e_st0, input logic e_st1, input logic e_mact,
    input logic [2:0] e_mop, input logic [31:0] e_mrs, input logic [31:0] e_mrt,
    input logic [1:0] e_own, input logic [1:0] e_rdsel, input logic [31:0] e_rdval);
    vec_t r;
    r.a0 = a0; r.op0 = op0; r.rs0 = rs0; r.rt0 = rt0;
    r.a1 = a1; r.op1 = op1; r.rs1 = rs1; r.rt1 = rt1;
    r.ms = ms; r.e_st0 = e_st0; r.e_st1 = e_st1; r.e_mact = e_mact;
    r.e_mop = e_mop; r.e_mrs = e_mrs; r.e_mrt = e_mrt;
    r.e_own = e_own; r.e_rdsel = e_rdsel; r.e_rdval = e_rdval;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_rd(input string tag);
    rd_exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, " rd0"}, req0_rd_data_3a, e.sel[0] ? e.val : 32'h0);
      chk({tag, " rd1"}, req1_rd_data_3a, e.sel[1] ? e.val : 32'h0);
    end
  endtask

  // One cycle: drive just after the edge, check mid-cycle, then advance.
  task automatic step(input vec_t x, input string tag);
    rd_exp_t e;
    req0_active_2a = x.a0; req0_opcode_2a = x.op0; req0_rs_data_2a = x.rs0; req0_rt_data_2a = x.rt0;
    req1_active_2a = x.a1; req1_opcode_2a = x.op1; req1_rs_data_2a = x.rs1; req1_rt_data_2a = x.rt1;
    mul_stall_2a = x.ms;
    #4;
    chk({tag, " stall0"}, 32'(req0_stall_2a), 32'(x.e_st0));
    chk({tag, " stall1"}, 32'(req1_stall_2a), 32'(x.e_st1));
    chk({tag, " mul_active"}, 32'(mul_active_2a), 32'(x.e_mact));
    chk({tag, " owner"}, 32'(owner), 32'(x.e_own));
    if (x.e_mact) begin
      chk({tag, " mul_op"}, 32'(mul_opcode_2a), 32'(x.e_mop));
      chk({tag, " mul_rs"}, mul_rs_data_2a, x.e_mrs);
      chk({tag, " mul_rt"}, mul_rt_data_2a, x.e_mrt);
    end
    pop_rd(tag);
    e.sel = x.e_rdsel;
    e.val = x.e_rdval;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_b = 1'b0;
    req0_active_2a = 1'b0; req0_opcode_2a = 3'd0; req0_rs_data_2a = 32'h0; req0_rt_data_2a = 32'h0;
    req1_active_2a = 1'b0; req1_opcode_2a = 3'd0; req1_rs_data_2a = 32'h0; req1_rt_data_2a = 32'h0;
    mul_stall_2a = 1'b0;

    // Table: tie from reset, MULT lock, stalled MFLO, rr_last=0 tie.
    tbl.push_back(v(0, 0, 0, 0,          0, 0, 0, 0,          0, 0, 0, 0, 0, 0, 0,          2'b00, 2'b00, 0));
    tbl.push_back(v(1, MFHI, 'h11, 'h22, 1, MFHI, 'h33, 'h44, 0, 0, 1, 1, MFHI, 'h11, 'h22, 2'b00, 2'b01, 32'hA5A5_0001));
    tbl.push_back(v(0, MFHI, 'h11, 'h22, 1, MFHI, 'h33, 'h44, 0, 0, 0, 1, MFHI, 'h33, 'h44, 2'b00, 2'b10, 32'hA5A5_0001));
    tbl.push_back(v(1, MULT, 3, 5,       0, 0, 0, 0,          0, 0, 0, 1, MULT, 3, 5,       2'b00, 2'b00, 0));
    tbl.push_back(v(0, 0, 0, 0,          1, MFLO, 0, 0,       0, 0, 1, 0, 0, 0, 0,          2'b01, 2'b00, 0));
    for (int i = 0; i < 7; i++)
      tbl.push_back(v(1, MFLO, 0, 0,     1, MFLO, 0, 0,       1, 1, 1, 1, MFLO, 0, 0,       2'b01, 2'b00, 0));
    tbl.push_back(v(1, MFLO, 0, 0,       1, MFLO, 0, 0,       0, 0, 1, 1, MFLO, 0, 0,       2'b01, 2'b01, 32'h0000_000F));
    tbl.push_back(v(0, 0, 0, 0,          1, MFLO, 5, 6,       0, 0, 0, 1, MFLO, 5, 6,       2'b00, 2'b10, 32'h0000_000F));
    tbl.push_back(v(1, MFHI, 0, 0,       0, 0, 0, 0,          0, 0, 0, 1, MFHI, 0, 0,       2'b00, 2'b01, 32'h0));
    tbl.push_back(v(1, DIV, 100, 7,      1, DIV, 100, 9,      0, 1, 0, 1, DIV, 100, 9,      2'b00, 2'b00, 0));

    #12;
    chk("reset owner", 32'(owner), 32'h0);
    chk("reset stall0", 32'(req0_stall_2a), 32'h0);
    chk("reset stall1", 32'(req1_stall_2a), 32'h0);
    chk("reset mul_active", 32'(mul_active_2a), 32'h0);
    chk("reset rd0", req0_rd_data_3a, 32'h0);
    chk("reset rd1", req1_rd_data_3a, 32'h0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // Timeout in OWN1 with req1 idle and req0 waiting.
    for (int i = 0; i < int'(LT); i++)
      step(v(1, MFLO, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0), "to_wait");
    step(v(1, MFLO, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, MFLO, 0, 0, 2'b00, 2'b01, 32'd11), "to_after");

    // Owner op on the expiry cycle keeps the lock and restarts the count.
    step(v(0, 0, 0, 0, 1, MTHI, 'h77, 0, 0, 0, 0, 1, MTHI, 'h77, 0, 2'b00, 2'b00, 0), "lock1");
    for (int i = 0; i < int'(LT) - 1; i++)
      step(v(1, MFLO, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0), "hold_a");
    step(v(1, MFLO, 0, 0, 1, MTHI, 'h88, 0, 0, 1, 0, 1, MTHI, 'h88, 0, 2'b10, 2'b00, 0), "expiry_mthi");
    for (int i = 0; i < int'(LT) - 1; i++)
      step(v(1, MFLO, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0), "hold_b");
    step(v(1, MFLO, 0, 0, 1, MFHI, 0, 0, 0, 1, 0, 1, MFHI, 0, 0, 2'b10, 2'b10, 32'h88), "own1_mfhi");

    // Async reset while owning with read data routed to req1.
    req1_active_2a = 1'b0;
    #1;
    pop_rd("pre_reset");
    chk("pre_reset owner", 32'(owner), 32'h2);
    rst_b = 1'b0;
    #1;
    chk("in_reset owner", 32'(owner), 32'h0);
    chk("in_reset rd0", req0_rd_data_3a, 32'h0);
    chk("in_reset rd1", req1_rd_data_3a, 32'h0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    sb.delete();
    step(v(1, MFHI, 1, 2, 1, MFHI, 3, 4, 0, 0, 1, 1, MFHI, 1, 2, 2'b00, 2'b01, 32'h88), "post_reset_tie");
    step(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0), "drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
